// File: rtl/uart_asc_pkg.sv
// Shared constants and state encodings for the ASCII number link.
// The transmitter and receiver both use these definitions.
package uart_asc_pkg;

    // ASCII bytes used in the frame
    localparam logic [7:0] ASC_0    = 8'd48;
    localparam logic [7:0] ASC_1    = 8'd49;
    localparam logic [7:0] ASC_A_LO = 8'd97;
    localparam logic [7:0] ASC_B_LO = 8'd98;
    localparam logic [7:0] ASC_A_UP = 8'd65;

    // Field order within a frame
    localparam logic [1:0] FLD_X = 2'd0;
    localparam logic [1:0] FLD_Y = 2'd1;
    localparam logic [1:0] FLD_Z = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIGIT = 2'd1,
        ST_SEP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bit counter width. A one-digit field still needs a one-bit counter.
    function automatic int bit_cnt_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/uart_num_asc_if.sv
// Byte stream handshake between the number serialiser and the UART transmitter.
interface uart_num_asc_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_field_sel.sv
// Combinational byte selector: the current digit of the current field in
// DIGIT, the field separator in SEP, and zero otherwise.
module uart_field_sel
    import uart_asc_pkg::*;
#(
    parameter int         DIGITS = 8,
    parameter int         BW     = 3,
    parameter logic [7:0] SEP_X  = ASC_A_LO,
    parameter logic [7:0] SEP_Y  = ASC_B_LO,
    parameter logic [7:0] SEP_Z  = ASC_A_UP
) (
    input  state_t            state,
    input  logic [1:0]        field,
    input  logic [BW-1:0]     bit_idx,
    input  logic [DIGITS-1:0] x_snap,
    input  logic [DIGITS-1:0] y_snap,
    input  logic [DIGITS-1:0] z_snap,
    output logic [7:0]        byte_out
);

    localparam int PADW = 1 << BW;

    logic [DIGITS-1:0] sel_vec;
    logic [PADW-1:0]   pad_vec;
    logic              cur_bit;

    // Pick the snapshot of the field being sent; field 3 yields zeros
    always_comb begin
        sel_vec = '0;
        case (field)
            FLD_X:   sel_vec = x_snap;
            FLD_Y:   sel_vec = y_snap;
            FLD_Z:   sel_vec = z_snap;
            default: sel_vec = '0;
        endcase
    end

    // Widen to a power of two so every counter value indexes a real bit
    genvar gi;
    generate
        for (gi = 0; gi < PADW; gi++) begin : g_pad
            if (gi < DIGITS) begin : g_bit
                assign pad_vec[gi] = sel_vec[gi];
            end else begin : g_zero
                assign pad_vec[gi] = 1'b0;
            end
        end
    endgenerate

    assign cur_bit = pad_vec[bit_idx];

    // Output byte as a function of state and field
    always_comb begin
        byte_out = 8'd0;
        case (state)
            ST_DIGIT: begin
                if (field != 2'd3) begin
                    byte_out = ASC_0 + {7'd0, cur_bit};
                end
            end
            ST_SEP: begin
                case (field)
                    FLD_X:   byte_out = SEP_X;
                    FLD_Y:   byte_out = SEP_Y;
                    FLD_Z:   byte_out = SEP_Z;
                    default: byte_out = 8'd0;
                endcase
            end
            default: byte_out = 8'd0;
        endcase
    end

endmodule

// File: rtl/uart_num_asc.sv
// Serialises a snapshot of three axis values as ASCII binary digits, MSB
// first, each field followed by a separator byte, over a valid/ready stream.
// DIGITS must lie in 1..32.
module uart_num_asc
    import uart_asc_pkg::*;
#(
    parameter int         DIGITS = 8,
    parameter logic [7:0] SEP_X  = ASC_A_LO,
    parameter logic [7:0] SEP_Y  = ASC_B_LO,
    parameter logic [7:0] SEP_Z  = ASC_A_UP
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [31:0]    xdatain,
    input  logic [31:0]    ydatain,
    input  logic [31:0]    zdatain,
    input  logic           load,
    input  logic           clr,
    uart_num_asc_if.master tx,
    output logic           busy,
    output logic           done
);

    localparam int            BW      = bit_cnt_width(DIGITS);
    localparam logic [BW-1:0] BIT_TOP = BW'(DIGITS - 1);

    state_t            state_reg, state_next;
    logic [1:0]        field_reg, field_next;
    logic [BW-1:0]     bit_reg,   bit_next;
    logic [DIGITS-1:0] x_reg, x_next;
    logic [DIGITS-1:0] y_reg, y_next;
    logic [DIGITS-1:0] z_reg, z_next;
    logic              sending;
    logic              handshake;
    logic [7:0]        byte_sel;

    // Bits above DIGITS-1 are never transmitted
    generate
        if (DIGITS < 32) begin : g_unused
            logic unused_hi;
            assign unused_hi = ^{xdatain[31:DIGITS], ydatain[31:DIGITS], zdatain[31:DIGITS]};
        end
    endgenerate

    // State, counters and snapshot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            field_reg <= 2'd0;
            bit_reg   <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
        end else begin
            state_reg <= state_next;
            field_reg <= field_next;
            bit_reg   <= bit_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            z_reg     <= z_next;
        end
    end

    // Next-state logic; clr overrides load and any handshake in flight
    always_comb begin
        state_next = state_reg;
        field_next = field_reg;
        bit_next   = bit_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        z_next     = z_reg;
        if (clr) begin
            state_next = ST_IDLE;
            field_next = 2'd0;
            bit_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (load) begin
                        x_next     = xdatain[DIGITS-1:0];
                        y_next     = ydatain[DIGITS-1:0];
                        z_next     = zdatain[DIGITS-1:0];
                        field_next = FLD_X;
                        bit_next   = BIT_TOP;
                        state_next = ST_DIGIT;
                    end
                end
                ST_DIGIT: begin
                    if (field_reg == 2'd3) begin
                        state_next = ST_IDLE;
                        field_next = 2'd0;
                    end else if (handshake) begin
                        if (bit_reg == '0) begin
                            state_next = ST_SEP;
                        end else begin
                            bit_next = bit_reg - 1'b1;
                        end
                    end
                end
                ST_SEP: begin
                    if (field_reg == 2'd3) begin
                        state_next = ST_IDLE;
                        field_next = 2'd0;
                    end else if (handshake) begin
                        if (field_reg == FLD_Z) begin
                            state_next = ST_DONE;
                        end else begin
                            field_next = field_reg + 2'd1;
                            bit_next   = BIT_TOP;
                            state_next = ST_DIGIT;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    field_next = 2'd0;
                    bit_next   = '0;
                end
            endcase
        end
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        sending = (state_reg == ST_DIGIT) || (state_reg == ST_SEP);
        busy    = sending;
        done    = (state_reg == ST_DONE);
    end

    assign handshake   = sending & tx.tx_ready;
    assign tx.tx_valid = sending;
    assign tx.tx_data  = byte_sel;

    uart_field_sel #(
        .DIGITS (DIGITS),
        .BW     (BW),
        .SEP_X  (SEP_X),
        .SEP_Y  (SEP_Y),
        .SEP_Z  (SEP_Z)
    ) u_field_sel (
        .state    (state_reg),
        .field    (field_reg),
        .bit_idx  (bit_reg),
        .x_snap   (x_reg),
        .y_snap   (y_reg),
        .z_snap   (z_reg),
        .byte_out (byte_sel)
    );

endmodule
